// File: rtl/line_tile_renderer.sv
// Tile-map line renderer: an 80x60 map of 2-bit line codes, expanded through an
// 8-row pattern table into a per-pixel on/off bit with a fixed 2-cycle latency.
module line_tile_renderer #(
  parameter int H_TILES = 80,
  parameter int V_TILES = 60,
  parameter int MAP_AW  = 13
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       in_valid,
  input  logic       wr_en,
  input  logic [6:0] wr_col,
  input  logic [5:0] wr_row,
  input  logic [1:0] wr_code,
  input  logic       clear,
  output logic       busy,
  output logic       pixel_on,
  output logic       out_valid
);

  localparam int NTILES = H_TILES * V_TILES;
  localparam logic [MAP_AW-1:0] LAST_ADDR = MAP_AW'(NTILES - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [MAP_AW-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // A clear pulse always (re)starts the sweep from entry 0, even mid-sweep.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (clear) begin
      state_d    = CLEAR;
      clr_addr_d = '0;
    end else if (state_q == CLEAR) begin
      if (clr_addr_q == LAST_ADDR) begin
        state_d    = IDLE;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + 1'b1;
      end
    end
  end

  assign busy = (state_q == CLEAR);

  // Single write port shared by the sweep and user writes.
  logic              usr_ok, mem_we;
  logic [MAP_AW-1:0] usr_addr, mem_waddr, mem_raddr;
  logic [1:0]        mem_wdata;
  logic              in_rng;

  assign usr_ok   = wr_en && !clear && (state_q == IDLE) &&
                    (wr_col < 7'(H_TILES)) && (wr_row < 6'(V_TILES));
  assign usr_addr = MAP_AW'(wr_row) * MAP_AW'(H_TILES) + MAP_AW'(wr_col);

  assign mem_we    = busy || usr_ok;
  assign mem_waddr = busy ? clr_addr_q : usr_addr;
  assign mem_wdata = busy ? 2'b00 : wr_code;

  // Off-screen reads are steered to entry 0 so the index never leaves the map.
  assign in_rng    = (DrawX < 10'(H_TILES * 8)) && (DrawY < 10'(V_TILES * 8));
  assign mem_raddr = in_rng ? MAP_AW'(DrawY[9:3]) * MAP_AW'(H_TILES) + MAP_AW'(DrawX[9:3])
                            : '0;

  logic [1:0] map_mem [NTILES];
  logic [1:0] code_q;

  always_ff @(posedge Clk) begin
    if (mem_we) map_mem[mem_waddr] <= mem_wdata;
    code_q <= map_mem[mem_raddr];
  end

  // Stage 1 side-band and the valid shift register.
  logic [2:0] row_q, bit_q;
  logic       inr_q;
  logic [1:0] vld_pipe_q;
  logic       pixel_on_q;

  logic [7:0] pat_rom [32];
  logic [7:0] pat;
  logic       pixel_on_d;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      case (2'(i >> 3))
        2'd1:    pat_rom[i] = 8'b0000_0001;
        2'd2:    pat_rom[i] = 8'b1000_0000;
        default: pat_rom[i] = 8'b0000_0000;
      endcase
    end
  end

  assign pat        = pat_rom[{code_q, row_q}];
  assign pixel_on_d = inr_q && vld_pipe_q[0] && pat[~bit_q];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row_q      <= '0;
      bit_q      <= '0;
      inr_q      <= 1'b0;
      vld_pipe_q <= '0;
      pixel_on_q <= 1'b0;
    end else begin
      row_q      <= DrawY[2:0];
      bit_q      <= DrawX[2:0];
      inr_q      <= in_rng;
      vld_pipe_q <= {vld_pipe_q[0], in_valid};
      pixel_on_q <= pixel_on_d;
    end
  end

  assign pixel_on  = pixel_on_q;
  assign out_valid = vld_pipe_q[1];

endmodule

// File: tb/tb_line_tile_renderer.sv
// Directed bench for line_tile_renderer: clear sweep timing, pattern expansion,
// range checks, read-before-write and clear/write priority.
module tb_line_tile_renderer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       in_valid = 1'b0;
  logic       wr_en = 1'b0;
  logic [6:0] wr_col = '0;
  logic [5:0] wr_row = '0;
  logic [1:0] wr_code = '0;
  logic       clear = 1'b0;
  logic       busy, pixel_on, out_valid;

  int total = 0;
  int bad   = 0;

  // Expectations for the inputs driven one and two cycles ago.
  logic       e1_live = 1'b0, e2_live = 1'b0;
  logic       e1_v, e1_p, e2_v, e2_p;
  logic [9:0] e1_x, e1_y, e2_x, e2_y;

  line_tile_renderer dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .in_valid(in_valid),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_code(wr_code),
    .clear(clear), .busy(busy), .pixel_on(pixel_on), .out_valid(out_valid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One cycle: check the result due now, then drive the next pixel.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic v, input logic p);
    @(negedge Clk);
    if (e2_live) begin
      chk($sformatf("out_valid(%0d,%0d)", e2_x, e2_y), 32'(out_valid), 32'(e2_v));
      chk($sformatf("pixel_on(%0d,%0d)", e2_x, e2_y), 32'(pixel_on), 32'(e2_p));
    end
    e2_live = e1_live; e2_v = e1_v; e2_p = e1_p; e2_x = e1_x; e2_y = e1_y;
    e1_live = 1'b1;    e1_v = v;    e1_p = p;    e1_x = x;    e1_y = y;
    DrawX = x; DrawY = y; in_valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic do_write(input logic [6:0] c, input logic [5:0] r, input logic [1:0] code);
    wr_col = c; wr_row = r; wr_code = code; wr_en = 1'b1;
    idle(1);
    wr_en = 1'b0;
  endtask

  // Probe the leftmost and rightmost pixel of every tile; all must be dark.
  task automatic scan_zero();
    for (int ty = 0; ty < 60; ty++)
      for (int tx = 0; tx < 80; tx++) begin
        step(10'(tx * 8),     10'(ty * 8 + tx % 8), 1'b1, 1'b0);
        step(10'(tx * 8 + 7), 10'(ty * 8 + tx % 8), 1'b1, 1'b0);
      end
    idle(2);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 6000) begin
      n++;
      idle(1);
    end
    chk(tag, 32'(n), 32'd4800);
  endtask

  initial begin
    // Reset with in_valid high: outputs must stay quiet.
    in_valid = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pixel_on", 32'(pixel_on), 32'd0);
    Reset = 1'b0;
    in_valid = 1'b0;
    count_busy("reset_sweep_len");
    chk("idle_after_sweep", 32'(busy), 32'd0);
    scan_zero();

    // Code 1 at tile (5,3): only the rightmost column lights.
    do_write(7'd5, 6'd3, 2'd1);
    for (int y = 24; y < 32; y++)
      for (int x = 40; x < 48; x++) step(10'(x), 10'(y), 1'b1, x == 47);
    step(10'd47, 10'd24, 1'b0, 1'b0);

    // Code 2 at (0,0) lights the leftmost column; reserved code 3 stays dark.
    do_write(7'd0, 6'd0, 2'd2);
    do_write(7'd1, 6'd0, 2'd3);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) step(10'(x), 10'(y), 1'b1, x == 0);

    // Out-of-range write must not wrap onto tile (0,1); off-screen pixel is dark
    // even though the tile it would alias to is lit.
    do_write(7'd80, 6'd0, 2'd1);
    do_write(7'd0, 6'd2, 2'd1);
    step(10'd7, 10'd8, 1'b1, 1'b0);
    step(10'd7, 10'd16, 1'b1, 1'b1);
    step(10'd647, 10'd10, 1'b1, 1'b0);
    step(10'd0, 10'd480, 1'b1, 1'b0);

    // Same-cycle write and read of tile (2,2) returns the old code.
    step(10'd23, 10'd16, 1'b1, 1'b0);
    wr_col = 7'd2; wr_row = 6'd2; wr_code = 2'd1; wr_en = 1'b1;
    idle(1);
    wr_en = 1'b0;
    step(10'd23, 10'd16, 1'b1, 1'b1);
    step(10'd22, 10'd16, 1'b1, 1'b0);
    idle(2);

    // Clear from IDLE with a colliding write, restart mid-sweep, write during sweep.
    chk("busy_before_clear", 32'(busy), 32'd0);
    clear = 1'b1; wr_col = 7'd3; wr_row = 6'd3; wr_code = 2'd1; wr_en = 1'b1;
    idle(1);
    clear = 1'b0; wr_en = 1'b0;
    chk("busy_after_clear", 32'(busy), 32'd1);
    idle(1998);
    chk("busy_mid_sweep", 32'(busy), 32'd1);
    clear = 1'b1; wr_col = 7'd4; wr_row = 6'd4; wr_code = 2'd2; wr_en = 1'b1;
    idle(1);
    clear = 1'b0; wr_en = 1'b0;
    begin
      int n;
      n = 0;
      while (busy && n < 6000) begin
        n++;
        if (n == 1000) begin
          wr_col = 7'd0; wr_row = 6'd0; wr_code = 2'd2; wr_en = 1'b1;
        end else begin
          wr_en = 1'b0;
        end
        idle(1);
      end
      wr_en = 1'b0;
      chk("restart_sweep_len", 32'(n), 32'd4800);
    end
    chk("idle_after_restart", 32'(busy), 32'd0);
    scan_zero();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_tile_renderer.md
Name: line_tile_renderer

Overview:
- Pixel-side consumer of the 2-bit line-code tile scheme (0 blank, 1 right edge, 2 left edge, 3 reserved).
- Holds an 80x60 tile map of line codes, written by the control logic, covering a 640x480 screen in 8x8 tiles.
- Expands each tile's code through the 4-code x 8-row line pattern table and returns a per-pixel on/off bit to the colour mapper for the sampler's grid overlay.

Parameters:
- H_TILES, 80, tiles per row
- V_TILES, 60, tile rows
- MAP_AW, 13, tile-map address width (ceil(log2(H_TILES*V_TILES)))

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- DrawX  in  10  pixel column
- DrawY  in  10  pixel row
- in_valid  in  1  DrawX/DrawY qualify this cycle
- wr_en  in  1  tile-map write strobe
- wr_col  in  7  tile column, 0..79
- wr_row  in  6  tile row, 0..59
- wr_code  in  2  line code to store
- clear  in  1  one-cycle pulse that starts a full-map clear
- busy  out  1  clear sweep in progress
- pixel_on  out  1  line pixel lit
- out_valid  out  1  pixel_on qualifies

Behaviour:

Reset:
- Asynchronous assertion forces pixel_on=0, out_valid=0, and both pipeline valid bits to 0.
- It also forces FSM=CLEAR with clr_addr=0 and busy=1.
- Map RAM contents are not reset asynchronously. The automatic sweep after reset zeroes them.

FSM (IDLE, CLEAR):
- CLEAR writes code 0 to map[clr_addr] each cycle and increments clr_addr.
- When clr_addr reaches H_TILES*V_TILES-1 (4799), that final entry is written and the FSM goes to IDLE on the next edge.
- A full sweep takes exactly 4800 cycles. busy=1 in CLEAR and 0 in IDLE.
- A clear pulse in IDLE enters CLEAR with clr_addr=0. busy rises on the next edge.
- A clear pulse during CLEAR restarts clr_addr at 0.
- Reset mid-sweep restarts the sweep from 0.

Writes:
- Accepted only in IDLE, with wr_col<80 and wr_row<60.
- Address = wr_row*80 + wr_col. Data is written at the clock edge.
- Writes are ignored during CLEAR and on the same cycle as a clear pulse (clear wins).
- Out-of-range coordinates are ignored, with no wrap-around.

Pixel pipeline (fixed 2-cycle latency, no stalls):
- Stage 1 (edge N):
  - Registers the map read at (DrawY>>3)*80 + (DrawX>>3).
  - Registers row = DrawY[2:0], bit = DrawX[2:0], the in-range flag (DrawX<640 && DrawY<480) and v1 = in_valid.
- Stage 2 (edge N+1):
  - Forms table address {code,row} (5 bits) and reads the 8-bit pattern.
  - Registers pixel_on = in_range & v1 & pattern[7-bit], and out_valid = v1.
  - Code 0 pattern = 00000000 on all rows.
  - Code 1 pattern = 00000001 on all rows (rightmost pixel, bit==7).
  - Code 2 pattern = 10000000 on all rows (leftmost pixel, bit==0).
  - Code 3 is reserved and reads as 00000000.
- Result: pixel_on/out_valid for inputs presented before edge N are visible after edge N+1.

Read/write and read/clear ordering:
- A map read and a write to the same address in the same cycle return the old value (read-before-write).
- Pixel reads continue during CLEAR and return the current RAM contents. There is no blanking.
- out_valid with in_valid=0 gives out_valid=0 two cycles later. pixel_on is 0 whenever out_valid=0.

Implementation:
- The tile map must infer a simple dual-port synchronous RAM of 4800x2: one write port (muxed between clear and user writes) and one read port.

Test Plan:
1. Reset pulse, then wait -> busy=1 for exactly 4800 cycles, then 0; every tile reads code 0, and a full-frame scan gives pixel_on=0 everywhere.
2. Write col=5,row=3,code=1; scan DrawY=24..31, DrawX=40..47 -> pixel_on=1 only at DrawX=47 on all 8 rows, with each result appearing 2 cycles after its input.
3. Write col=0,row=0,code=2 and col=1,row=0,code=3 -> pixel_on=1 only at DrawX=0 for DrawY=0..7; tile (1,0) stays blank.
4. Out-of-range: write col=80,row=0,code=1 -> no map change. Probe DrawX=645,DrawY=10 with in_valid=1 -> out_valid=1, pixel_on=0.
5. Same-cycle write code=1 and read of tile (2,2) -> that pixel returns the old value 0; the next frame returns 1 at DrawX=23.
6. Clear pulse mid-sweep at cycle 2000, plus wr_en during the sweep and on the clear cycle -> busy stays high for 4800 cycles after the second pulse; all writes are dropped and the map ends all-zero.
